// File: rtl/ysyx_25010008_axi_sram_if.sv
// AXI4-Lite channel bundle between the LSU (master) and the data SRAM (slave).
interface ysyx_25010008_axi_sram_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ysyx_25010008_axi_sram.sv
// AXI4-Lite data SRAM behind the LSU: one transaction at a time, programmable
// read/write wait states, out-of-range accesses answered with DECERR.
module ysyx_25010008_axi_sram #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned RD_LAT      = 2,
    parameter int unsigned WR_LAT      = 1
) (
    input logic                     clock,
    input logic                     reset,
    ysyx_25010008_axi_sram_if.slave axi
);
    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_END = {1'b0, ADDR_BASE} + 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [7:0]  RD_LAT_C = 8'(RD_LAT);
    localparam logic [7:0]  WR_LAT_C = 8'(WR_LAT);
    localparam logic [1:0]  OKAY     = 2'b00;
    localparam logic [1:0]  DECERR   = 2'b11;

    typedef enum logic [2:0] {
        IDLE, RD_WAIT, RD_RESP, WR_DATA, WR_WAIT, WR_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [1:0]         rresp_q, rresp_d;
    logic [1:0]         bresp_q, bresp_d;
    logic               hit;
    logic               mem_we;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        mem [DEPTH_WORDS];

    // One latched address serves both paths; byte offset bits are dropped by the shift.
    assign hit = (addr_q >= ADDR_BASE) && ({1'b0, addr_q} < ADDR_END);
    assign idx = IDX_W'((addr_q - ADDR_BASE) >> 2);

    assign axi.arready = (state_q == IDLE);
    assign axi.awready = (state_q == IDLE) && !axi.arvalid;
    assign axi.wready  = (state_q == WR_DATA);
    assign axi.rvalid  = (state_q == RD_RESP);
    assign axi.bvalid  = (state_q == WR_RESP);
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign axi.bresp   = bresp_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        bresp_d = bresp_q;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (axi.arvalid) begin
                    addr_d  = axi.araddr;
                    cnt_d   = '0;
                    state_d = RD_WAIT;
                end else if (axi.awvalid) begin
                    addr_d  = axi.awaddr;
                    state_d = WR_DATA;
                end
            end
            RD_WAIT: begin
                if (cnt_q == RD_LAT_C) begin
                    rdata_d = hit ? mem[idx] : '0;
                    rresp_d = hit ? OKAY : DECERR;
                    state_d = RD_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RD_RESP: begin
                if (axi.rready) state_d = IDLE;
            end
            WR_DATA: begin
                if (axi.wvalid) begin
                    wdata_d = axi.wdata;
                    wstrb_d = axi.wstrb;
                    cnt_d   = '0;
                    state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (cnt_q == WR_LAT_C) begin
                    mem_we  = hit;
                    bresp_d = hit ? OKAY : DECERR;
                    state_d = WR_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WR_RESP: begin
                if (axi.bready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            rresp_q <= '0;
            bresp_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
            bresp_q <= bresp_d;
        end
    end

    always_ff @(posedge clock) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
    end

    // The array has no reset so it can be preloaded; a reset aborts a pending write via state_q.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ysyx_25010008_axi_sram.sv
// Directed bench for the AXI4-Lite data SRAM: one slow instance and one zero-latency instance.
module tb_ysyx_25010008_axi_sram;
    localparam int         TMO    = 100;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] DECERR = 2'b11;

    logic        clock   = 1'b0;
    logic        reset   = 1'b1;
    logic        sel     = 1'b0;
    logic [31:0] araddr  = '0;
    logic [31:0] awaddr  = '0;
    logic [31:0] wdata   = '0;
    logic [3:0]  wstrb   = '0;
    logic        arvalid = 1'b0;
    logic        rready  = 1'b0;
    logic        awvalid = 1'b0;
    logic        wvalid  = 1'b0;
    logic        bready  = 1'b0;
    logic        arready, rvalid, awready, wready, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;
    int          compared   = 0;
    int          mismatched = 0;

    always #5 clock = ~clock;

    ysyx_25010008_axi_sram_if if_a ();
    ysyx_25010008_axi_sram_if if_b ();

    // Instance A: RD_LAT=2, WR_LAT=3. Instance B: zero wait states.
    ysyx_25010008_axi_sram #(.RD_LAT(2), .WR_LAT(3)) dut_a (.clock(clock), .reset(reset), .axi(if_a));
    ysyx_25010008_axi_sram #(.RD_LAT(0), .WR_LAT(0)) dut_b (.clock(clock), .reset(reset), .axi(if_b));

    assign if_a.araddr  = araddr;
    assign if_a.awaddr  = awaddr;
    assign if_a.wdata   = wdata;
    assign if_a.wstrb   = wstrb;
    assign if_a.arvalid = arvalid && !sel;
    assign if_a.rready  = rready  && !sel;
    assign if_a.awvalid = awvalid && !sel;
    assign if_a.wvalid  = wvalid  && !sel;
    assign if_a.bready  = bready  && !sel;
    assign if_b.araddr  = araddr;
    assign if_b.awaddr  = awaddr;
    assign if_b.wdata   = wdata;
    assign if_b.wstrb   = wstrb;
    assign if_b.arvalid = arvalid && sel;
    assign if_b.rready  = rready  && sel;
    assign if_b.awvalid = awvalid && sel;
    assign if_b.wvalid  = wvalid  && sel;
    assign if_b.bready  = bready  && sel;

    assign arready = sel ? if_b.arready : if_a.arready;
    assign awready = sel ? if_b.awready : if_a.awready;
    assign wready  = sel ? if_b.wready  : if_a.wready;
    assign rvalid  = sel ? if_b.rvalid  : if_a.rvalid;
    assign bvalid  = sel ? if_b.bvalid  : if_a.bvalid;
    assign rdata   = sel ? if_b.rdata   : if_a.rdata;
    assign rresp   = sel ? if_b.rresp   : if_a.rresp;
    assign bresp   = sel ? if_b.bresp   : if_a.bresp;

    // wlat counts cycles from the W handshake cycle (0) to the first cycle with bvalid high.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output int wlat);
        int n;
        awaddr = a; awvalid = 1'b1; #1;
        n = 0;
        while (awready !== 1'b1 && n < TMO) begin @(posedge clock); #1; n++; end
        if (n >= TMO) begin compared++; mismatched++; $display("FAIL wr_aw_timeout addr %h: awready never 1", a); end
        @(posedge clock); #1;
        awvalid = 1'b0;
        wdata = d; wstrb = s; wvalid = 1'b1; #1;
        n = 0;
        while (wready !== 1'b1 && n < TMO) begin @(posedge clock); #1; n++; end
        if (n >= TMO) begin compared++; mismatched++; $display("FAIL wr_w_timeout addr %h: wready never 1", a); end
        @(posedge clock); #1;
        wvalid = 1'b0; bready = 1'b1; wlat = 1;
        while (bvalid !== 1'b1 && wlat < TMO) begin @(posedge clock); #1; wlat++; end
        if (wlat >= TMO) begin compared++; mismatched++; $display("FAIL wr_b_timeout addr %h: bvalid never 1", a); end
        resp = bresp;
        @(posedge clock); #1;
        bready = 1'b0;
    endtask

    // rlat counts cycles from the AR handshake cycle (0) to the first cycle with rvalid high.
    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                            output int rlat);
        int n;
        araddr = a; arvalid = 1'b1; #1;
        n = 0;
        while (arready !== 1'b1 && n < TMO) begin @(posedge clock); #1; n++; end
        if (n >= TMO) begin compared++; mismatched++; $display("FAIL rd_ar_timeout addr %h: arready never 1", a); end
        @(posedge clock); #1;
        arvalid = 1'b0; rlat = 1;
        while (rvalid !== 1'b1 && rlat < TMO) begin @(posedge clock); #1; rlat++; end
        if (rlat >= TMO) begin compared++; mismatched++; $display("FAIL rd_r_timeout addr %h: rvalid never 1", a); end
        d = rdata; resp = rresp;
        rready = 1'b1;
        @(posedge clock); #1;
        rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [40:0] exp_v, got_v;
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        exp_v = {5'b11000, 32'h0, 2'b00, 2'b00};
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            got_v = {arready, awready, wready, rvalid, bvalid, rdata, rresp, bresp};
            compared++;
            if (got_v !== exp_v) begin
                mismatched++;
                $display("FAIL reset_outputs dut%0d: got %h, want %h", s, got_v, exp_v);
            end
        end
        sel = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_write_read();
        logic [31:0] d; logic [1:0] r; int lat;
        sel = 1'b0;
        axi_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, r, lat);
        compared++; if (r !== OKAY) begin mismatched++; $display("FAIL wr_bresp: got %b, want 00", r); end
        compared++; if (lat !== 5) begin mismatched++; $display("FAIL wr_latency: got %0d, want 5", lat); end
        axi_read(32'h8000_0010, d, r, lat);
        compared++; if (d !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL rd_data: got %h, want deadbeef", d); end
        compared++; if (r !== OKAY) begin mismatched++; $display("FAIL rd_rresp: got %b, want 00", r); end
        compared++; if (lat !== 4) begin mismatched++; $display("FAIL rd_latency: got %0d, want 4", lat); end
    endtask

    task automatic test_byte_strobes();
        logic [31:0] d; logic [1:0] r; int lat;
        sel = 1'b0;
        axi_write(32'h8000_0010, 32'h0000_00AA, 4'b0001, r, lat);
        axi_read(32'h8000_0010, d, r, lat);
        compared++; if (d !== 32'hDEAD_BEAA) begin mismatched++; $display("FAIL strb_0001: got %h, want deadbeaa", d); end
        axi_write(32'h8000_0010, 32'h5566_0000, 4'b1100, r, lat);
        axi_read(32'h8000_0010, d, r, lat);
        compared++; if (d !== 32'h5566_BEAA) begin mismatched++; $display("FAIL strb_1100: got %h, want 5566beaa", d); end
        axi_write(32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, r, lat);
        compared++; if (r !== OKAY) begin mismatched++; $display("FAIL strb_0000_bresp: got %b, want 00", r); end
        axi_read(32'h8000_0013, d, r, lat);
        compared++; if (d !== 32'h5566_BEAA) begin mismatched++; $display("FAIL strb_0000_unaligned_rd: got %h, want 5566beaa", d); end
    endtask

    task automatic test_decode_error();
        logic [31:0] d; logic [1:0] r; int lat;
        sel = 1'b0;
        axi_write(32'h8000_0000, 32'h0123_4567, 4'hF, r, lat);
        axi_write(32'h8000_3FFC, 32'h89AB_CDEF, 4'hF, r, lat);
        compared++; if (r !== OKAY) begin mismatched++; $display("FAIL last_word_bresp: got %b, want 00", r); end
        axi_read(32'h8000_3FFC, d, r, lat);
        compared++; if (d !== 32'h89AB_CDEF || r !== OKAY) begin mismatched++; $display("FAIL last_word_rd: got %h/%b, want 89abcdef/00", d, r); end
        axi_read(32'h7FFF_FFFC, d, r, lat);
        compared++; if (d !== 32'h0 || r !== DECERR) begin mismatched++; $display("FAIL below_base_rd: got %h/%b, want 00000000/11", d, r); end
        axi_write(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, r, lat);
        compared++; if (r !== DECERR) begin mismatched++; $display("FAIL above_top_bresp: got %b, want 11", r); end
        axi_read(32'h8000_0000, d, r, lat);
        compared++; if (d !== 32'h0123_4567) begin mismatched++; $display("FAIL miss_no_write_word0: got %h, want 01234567", d); end
        axi_read(32'h8000_4000, d, r, lat);
        compared++; if (d !== 32'h0 || r !== DECERR) begin mismatched++; $display("FAIL above_top_rd: got %h/%b, want 00000000/11", d, r); end
    endtask

    task automatic test_arb_and_stall();
        logic [31:0] d; logic [1:0] r; int lat, n, aw_leak, unstable;
        sel = 1'b0;
        axi_write(32'h8000_0040, 32'h0BAD_F00D, 4'hF, r, lat);
        araddr = 32'h8000_0040; arvalid = 1'b1;
        awaddr = 32'h8000_0044; awvalid = 1'b1; #1;
        compared++;
        if (arready !== 1'b1 || awready !== 1'b0) begin
            mismatched++; $display("FAIL tie_ready: got arready %b awready %b, want 1/0", arready, awready);
        end
        @(posedge clock); #1;
        arvalid = 1'b0; aw_leak = 0; n = 0;
        while (rvalid !== 1'b1 && n < TMO) begin
            if (awready !== 1'b0) aw_leak++;
            @(posedge clock); #1; n++;
        end
        if (n >= TMO) begin compared++; mismatched++; $display("FAIL tie_rvalid_timeout: rvalid never 1"); end
        d = rdata; r = rresp; unstable = 0;
        for (int i = 0; i < 5; i++) begin
            if (awready !== 1'b0) aw_leak++;
            @(posedge clock); #1;
            if (rvalid !== 1'b1 || rdata !== d || rresp !== r) unstable++;
        end
        compared++; if (d !== 32'h0BAD_F00D || r !== OKAY) begin mismatched++; $display("FAIL tie_read_data: got %h/%b, want 0badf00d/00", d, r); end
        compared++; if (unstable !== 0) begin mismatched++; $display("FAIL rvalid_hold_stable: got %0d unstable cycles, want 0", unstable); end
        compared++; if (aw_leak !== 0) begin mismatched++; $display("FAIL awready_during_read: got %0d cycles high, want 0", aw_leak); end
        rready = 1'b1;
        @(posedge clock); #1;
        rready = 1'b0; #1;
        compared++; if (awready !== 1'b1) begin mismatched++; $display("FAIL awready_back_in_idle: got %b, want 1", awready); end
        axi_write(32'h8000_0044, 32'h1357_9BDF, 4'hF, r, lat);
        compared++; if (r !== OKAY) begin mismatched++; $display("FAIL tie_write_bresp: got %b, want 00", r); end
        axi_read(32'h8000_0044, d, r, lat);
        compared++; if (d !== 32'h1357_9BDF) begin mismatched++; $display("FAIL tie_write_readback: got %h, want 13579bdf", d); end
    endtask

    task automatic test_reset_in_write();
        logic [31:0] d; logic [1:0] r; int lat;
        logic [34:0] got_v;
        sel = 1'b0;
        axi_write(32'h8000_0020, 32'h1122_3344, 4'hF, r, lat);
        axi_read(32'h8000_0020, d, r, lat);
        awaddr = 32'h8000_0020; awvalid = 1'b1; #1;
        @(posedge clock); #1;
        awvalid = 1'b0;
        wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1; #1;
        @(posedge clock); #1;
        wvalid = 1'b0;
        // Now in WR_WAIT with one wait cycle elapsed and two still to go.
        @(posedge clock); #1;
        reset = 1'b0; #1;
        got_v = {bvalid, arready, awready, rdata};
        compared++;
        if (got_v !== {3'b011, 32'h0}) begin
            mismatched++; $display("FAIL reset_mid_write_outputs: got %h, want %h", got_v, {3'b011, 32'h0});
        end
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        axi_read(32'h8000_0020, d, r, lat);
        compared++; if (d !== 32'h1122_3344) begin mismatched++; $display("FAIL reset_drops_write: got %h, want 11223344", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] model [16];
        logic [31:0] d, a, wd; logic [3:0] st; logic [1:0] r; int lat, w;
        sel = 1'b1;
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            axi_write(32'h8000_0000 + 32'(i * 4), model[i], 4'hF, r, lat);
            if (i == 0) begin
                compared++; if (lat !== 2) begin mismatched++; $display("FAIL b2b_wr_latency: got %0d, want 2", lat); end
            end
        end
        for (int k = 0; k < 100; k++) begin
            w = $urandom_range(0, 15);
            a = 32'h8000_0000 + 32'(w * 4);
            if ($urandom_range(0, 1) == 0) begin
                axi_read(a, d, r, lat);
                compared++;
                if (d !== model[w] || r !== OKAY || lat !== 2) begin
                    mismatched++;
                    $display("FAIL b2b_read op%0d addr %h: got %h/%b lat %0d, want %h/00 lat 2", k, a, d, r, lat, model[w]);
                end
            end else begin
                wd = $urandom;
                st = 4'($urandom_range(0, 15));
                axi_write(a, wd, st, r, lat);
                for (int b = 0; b < 4; b++) if (st[b]) model[w][8*b +: 8] = wd[8*b +: 8];
                compared++;
                if (r !== OKAY || lat !== 2) begin
                    mismatched++; $display("FAIL b2b_write op%0d addr %h: got %b lat %0d, want 00 lat 2", k, a, r, lat);
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            axi_read(32'h8000_0000 + 32'(i * 4), d, r, lat);
            compared++;
            if (d !== model[i]) begin mismatched++; $display("FAIL b2b_sweep word%0d: got %h, want %h", i, d, model[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_strobes();
        test_decode_error();
        test_arb_and_stall();
        test_reset_in_write();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d compared so far", compared);
        $fatal(1, "watchdog expired");
    end
endmodule
